// File: rtl/alu_sequencer.sv
// alu_sequencer: two-requester round-robin front end for the 32-bit ALU.
//   Latches one request, holds the ALU inputs for ALU_LAT posedges, then
//   captures rez/flags/ready into a single tagged response.
// Latency: accepted request -> rsp_valid after ALU_LAT cycles in ISSUE;
//   issue spacing is at least ALU_LAT+2 cycles.
// Backpressure: rsp_valid holds until rsp_ready; no request is accepted
//   while a transaction is in flight (reqN_ready low).
// Ports:
//   clk, reset (async, active-high)
//   req0_*/req1_*  : valid/ready request ports (op, a, b, mode)
//   rsp_*          : valid/ready response (id, rez, flags {V,C,N,Z}, err)
//   alu_*          : drive to / results from the ALU (ALU evaluates on negedge)
//   flags_q        : architectural flags register
// Optional feature macro: ALU_SEQ_FLAGS_REG_EN
//   defined     -> flags_q loads rsp_flags on a successful op-mode handshake
//   not defined -> flags_q tied to 4'b0000
module alu_sequencer #(
  parameter int ALU_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [5:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [1:0]  req0_mode,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [5:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [1:0]  req1_mode,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_rez,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err,
  output logic [5:0]  alu_op_code,
  output logic [31:0] alu_val,
  output logic [31:0] alu_reg0,
  output logic        alu_move,
  output logic        alu_store,
  input  logic        alu_ready,
  input  logic [3:0]  alu_flags,
  input  logic [31:0] alu_rez,
  output logic [3:0]  flags_q
);

  localparam int LCW = (ALU_LAT > 2) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             rr_ptr;
  logic [LCW-1:0]   lat_cnt;

  logic [5:0]       txn_op;
  logic [31:0]      txn_a;
  logic [31:0]      txn_b;
  logic [1:0]       txn_mode;
  logic             txn_id;

  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             capture;

  // rr_ptr's requester wins a tie; otherwise whichever one is valid.
  // The two grants are mutually exclusive by construction.
  assign grant0  = req0_valid & (~rr_ptr | ~req1_valid);
  assign grant1  = req1_valid & ( rr_ptr | ~req0_valid);
  assign accept  = (state == IDLE) & (grant0 | grant1) & ~reset;
  assign capture = (state == ISSUE) & (lat_cnt == LCW'(ALU_LAT - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = ISSUE;
      ISSUE:   if (capture)   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Outputs: ALU inputs are zero outside ISSUE so the ALU sees a clean
  // no-op between transactions. Ready is masked during reset so every
  // output reads 0 while reset is held.
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp_valid   = 1'b0;
    alu_op_code = 6'd0;
    alu_val     = 32'd0;
    alu_reg0    = 32'd0;
    alu_move    = 1'b0;
    alu_store   = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = grant0 & ~reset;
        req1_ready = grant1 & ~reset;
      end
      ISSUE: begin
        alu_op_code = txn_op;
        alu_val     = txn_b;
        alu_reg0    = txn_a;
        alu_move    = (txn_mode == 2'b01);
        alu_store   = (txn_mode == 2'b10);
      end
      RESP: begin
        rsp_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Transaction latch, hold counter and response capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr    <= 1'b0;
      lat_cnt   <= '0;
      txn_op    <= 6'd0;
      txn_a     <= 32'd0;
      txn_b     <= 32'd0;
      txn_mode  <= 2'd0;
      txn_id    <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_rez   <= 32'd0;
      rsp_flags <= 4'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        txn_id   <= grant1;
        txn_op   <= grant1 ? req1_op   : req0_op;
        txn_a    <= grant1 ? req1_a    : req0_a;
        txn_b    <= grant1 ? req1_b    : req0_b;
        txn_mode <= grant1 ? req1_mode : req0_mode;
        rr_ptr   <= ~grant1;
        lat_cnt  <= '0;
      end else if (state == ISSUE) begin
        lat_cnt  <= lat_cnt + LCW'(1);
      end

      // An ALU not-ready (unknown opcode) zeroes the payload so consumers
      // never see a stale or garbage result alongside err.
      if (capture) begin
        rsp_id    <= txn_id;
        rsp_err   <= ~alu_ready;
        rsp_rez   <= alu_ready ? alu_rez   : 32'd0;
        rsp_flags <= alu_ready ? alu_flags : 4'd0;
      end
    end
  end

`ifdef ALU_SEQ_FLAGS_REG_EN
  // Only real ALU ops (mode 00, and 11 which behaves as 00) update the
  // architectural flags; move/store and errored ops leave them alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 4'd0;
    end else if ((state == RESP) && rsp_ready && ~rsp_err &&
                 ((txn_mode == 2'b00) || (txn_mode == 2'b11))) begin
      flags_q <= rsp_flags;
    end
  end
`else
  assign flags_q = 4'b0000;
`endif

endmodule
